bus_region_controller: RTL and testbench
========================================

// Module: bus_region_controller
// PURPOSE
//  Parametrised, registered address-decode and transaction controller between the RISC-V core's
//  data bus and its N memory-mapped slaves (ROM, RAM, IO, graphics, keyboard, UART, ...).
//  Matches each request against N inclusive [base,limit] windows and selects one slave.
//  Holds the select until that slave acknowledges, then returns its read data to the core.
//  Unmapped accesses and slave timeouts end as a bus error; the controller logs the address and a count.
// PARAMETERS
//  ADDR_W        32                               address width
//  DATA_W        32                               data width
//  N_REGIONS     6                                number of slave windows
//  REGION_BASE   {N_REGIONS{ADDR_W}} packed       window k base at [k*ADDR_W +: ADDR_W], inclusive
//  REGION_LIMIT  {N_REGIONS{ADDR_W}} packed       window k limit at [k*ADDR_W +: ADDR_W], inclusive
//  TIMEOUT       255                              max ACCESS cycles without ack; must be >= 1
//  ERRCNT_W      8                                width of error counter
// PORTS
//  clk        in   1                  system clock
//  reset      in   1                  synchronous, active-high reset
//  m_req      in   1                  core request; sampled only in IDLE
//  m_addr     in   ADDR_W             request address; sampled with m_req
//  m_busy     out  1                  high whenever state != IDLE
//  m_ack      out  1                  1-cycle pulse: transaction complete, m_rdata valid
//  m_err      out  1                  1-cycle pulse: unmapped address or timeout
//  m_rdata    out  DATA_W             registered read data; holds until next m_ack
//  s_sel      out  N_REGIONS          one-hot slave select, registered
//  s_addr     out  ADDR_W             latched request address, stable while s_sel != 0
//  s_ack      in   N_REGIONS          per-slave acknowledge
//  s_rdata    in   N_REGIONS*DATA_W   per-slave read data, slave k at [k*DATA_W +: DATA_W]
//  err_addr   out  ADDR_W             address of most recent error
//  err_count  out  ERRCNT_W           saturating error count
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0, including m_rdata, err_addr and err_count; timeout counter 0.
//    A reset during ACCESS aborts the transaction. No m_ack or m_err is issued for it.
//  - Hit: BASE_k <= addr <= LIMIT_k, unsigned compare, both bounds inclusive.
//    If windows overlap, the lowest index wins. s_sel is always one-hot or zero.
//  - FSM IDLE -> ACCESS | ERROR; ACCESS -> IDLE | ERROR; ERROR -> IDLE after exactly one cycle.
//  - IDLE, m_req=1 at edge E: latch m_addr into s_addr and clear the timeout counter.
//    On a hit, enter ACCESS with s_sel[k]=1 from E onward. On a miss, enter ERROR.
//  - ACCESS: the timeout counter increments every cycle. Only s_ack[k] of the selected slave counts;
//    acks from other slaves are ignored.
//  - ACCESS with s_ack[k]=1 at edge F: m_rdata <= s_rdata[k] and m_ack=1 for the cycle after F.
//    s_sel clears at F and the FSM returns to IDLE. Minimum latency: m_req at edge E gives m_ack in cycle E+2.
//  - ACCESS, counter reaches TIMEOUT with no ack: s_sel clears and the FSM enters ERROR.
//    If s_ack arrives on the same edge the counter reaches TIMEOUT, the ack wins.
//  - ERROR: m_err=1 for exactly one cycle and err_addr <= s_addr.
//    err_count increments and saturates at 2^ERRCNT_W-1. m_rdata is unchanged.
//  - m_req while m_busy=1 is ignored and not queued; the core re-issues after m_busy falls.
//    A new request is accepted on the cycle m_ack or m_err is high, because the state is IDLE then.
//  - m_ack and m_err are never high together. s_addr holds its value after a transaction completes.
// TESTING
//  (default map: 0 ROM 0000_0000-0000_7FFF, 1 IO 0040_0000-0040_FFFF, 2 GFX 0401_0000-0401_000F,
//   3 RAM 0800_0000-0BFF_FFFF, 4 KBD 0500_0000-0500_000F, 5 UART 0500_0010-0500_001F; TIMEOUT=4)
//  1 req 0x0500001F, s_ack[5]=1 immediately -> s_sel=6'b100000 one cycle, m_ack with m_rdata=slave5 data,
//    latency 2.
//  2 Boundaries: req 0x00007FFF -> sel 0; 0x00008000 -> m_err, err_addr=0x00008000, err_count=1;
//    0x0BFFFFFF -> sel 3.
//  3 req 0x08000000, no ack -> m_err after 4 ACCESS cycles, s_sel cleared.
//    Repeat with ack on the 4th cycle -> m_ack, no m_err.
//  4 During ACCESS to slave 1, pulse s_ack[3] and a 2nd m_req -> both ignored.
//    s_ack[1] then gives m_ack; the next request accepted is the re-issued one.
//  5 Force 260 unmapped requests with ERRCNT_W=8 -> err_count stops at 255.
//  6 Assert reset mid-ACCESS -> all outputs 0 next cycle; no m_ack/m_err; a fresh request then completes normally.

Source files
------------

// File: rtl/bus_region_controller.sv
// rtl/bus_region_controller.sv - registered address decode and transaction controller for N slave windows
module bus_region_controller #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_REGIONS = 6,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {
        32'h0500_0010, 32'h0500_0000, 32'h0800_0000,
        32'h0401_0000, 32'h0040_0000, 32'h0000_0000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT = {
        32'h0500_001F, 32'h0500_000F, 32'h0BFF_FFFF,
        32'h0401_000F, 32'h0040_FFFF, 32'h0000_7FFF},
    parameter int TIMEOUT   = 255,
    parameter int ERRCNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        m_req,
    input  logic [ADDR_W-1:0]           m_addr,
    output logic                        m_busy,
    output logic                        m_ack,
    output logic                        m_err,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [N_REGIONS-1:0]        s_sel,
    output logic [ADDR_W-1:0]           s_addr,
    input  logic [N_REGIONS-1:0]        s_ack,
    input  logic [N_REGIONS*DATA_W-1:0] s_rdata,
    output logic [ADDR_W-1:0]           err_addr,
    output logic [ERRCNT_W-1:0]         err_count
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TCNT_W-1:0]   tcnt;
    logic [N_REGIONS-1:0] hit_sel;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdata;
    logic                accept;
    logic                done_ack;
    logic                time_out;
    logic                err_exit;

    // Walk from the highest window down so the lowest matching index is the one left standing.
    always_comb begin
        hit_sel = '0;
        for (int k = N_REGIONS - 1; k >= 0; k--) begin
            if (m_addr >= REGION_BASE[k*ADDR_W +: ADDR_W] &&
                m_addr <= REGION_LIMIT[k*ADDR_W +: ADDR_W]) begin
                hit_sel = N_REGIONS'(1) << k;
            end
        end
    end

    // s_sel is one-hot, so masking makes foreign acks invisible.
    always_comb begin
        sel_ack   = |(s_ack & s_sel);
        sel_rdata = '0;
        for (int k = 0; k < N_REGIONS; k++) begin
            if (s_sel[k]) begin
                sel_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_ack   = 1'b0;
        time_out   = 1'b0;
        err_exit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_req) begin
                    accept     = 1'b1;
                    state_next = (|hit_sel) ? ST_ACCESS : ST_ERROR;
                end
            end
            ST_ACCESS: begin
                // The ack is tested first so it beats a timeout landing on the same edge.
                if (sel_ack) begin
                    done_ack   = 1'b1;
                    state_next = ST_IDLE;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    time_out   = 1'b1;
                    state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                err_exit   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_ack     <= 1'b0;
            m_err     <= 1'b0;
            m_rdata   <= '0;
            s_sel     <= '0;
            s_addr    <= '0;
            err_addr  <= '0;
            err_count <= '0;
            tcnt      <= '0;
        end else begin
            m_ack <= done_ack;
            m_err <= err_exit;
            if (accept) begin
                s_addr <= m_addr;
                s_sel  <= hit_sel;
                tcnt   <= '0;
            end
            if (state == ST_ACCESS) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            if (done_ack) begin
                m_rdata <= sel_rdata;
                s_sel   <= '0;
            end
            if (time_out) begin
                s_sel <= '0;
            end
            if (err_exit) begin
                err_addr <= s_addr;
                if (err_count != {ERRCNT_W{1'b1}}) begin
                    err_count <= err_count + ERRCNT_W'(1);
                end
            end
        end
    end

    assign m_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_region_controller.sv
// tb/tb_bus_region_controller.sv - randomized transaction-level bench for bus_region_controller
module tb_bus_region_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 6;
    localparam int TO = 4;
    localparam int EW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_req;
    logic [AW-1:0]     m_addr;
    logic              m_busy;
    logic              m_ack;
    logic              m_err;
    logic [DW-1:0]     m_rdata;
    logic [NR-1:0]     s_sel;
    logic [AW-1:0]     s_addr;
    logic [NR-1:0]     s_ack;
    logic [NR*DW-1:0]  s_rdata;
    logic [AW-1:0]     err_addr;
    logic [EW-1:0]     err_count;

    int n_pass = 0;
    int n_total = 0;

    logic [AW-1:0] base_t  [NR];
    logic [AW-1:0] limit_t [NR];
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_err_addr;
    int            exp_err_count;

    bus_region_controller #(.TIMEOUT(TO), .ERRCNT_W(EW)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr),
        .m_busy(m_busy), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_sel(s_sel), .s_addr(s_addr), .s_ack(s_ack), .s_rdata(s_rdata),
        .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [AW-1:0] a);
        for (int k = 0; k < NR; k++) begin
            if (a >= base_t[k] && a <= limit_t[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int r;
        int k;
        r = $urandom_range(0, 9);
        k = $urandom_range(0, NR - 1);
        if (r < 2) return base_t[k];
        if (r < 4) return limit_t[k];
        if (r < 6) return $urandom_range(limit_t[k], base_t[k]);
        if (r == 6) return limit_t[k] + 1;
        if (r == 7) return base_t[k] - 1;
        return $urandom;
    endfunction

    task automatic model_reset();
        exp_rdata     = '0;
        exp_err_addr  = '0;
        exp_err_count = 0;
    endtask

    // Called #1 after a clock edge; d = ACCESS edges that pass before the selected slave acks.
    task automatic run_txn(input logic [AW-1:0] addr, input int d, input bit spur);
        int            k;
        int            exp_lat;
        int            lat;
        int            hold;
        bit            exp_ack;
        logic [NR-1:0] onehot;
        logic [NR-1:0] stray;
        logic [DW-1:0] exp_data;
        k = decode(addr);
        onehot = (k >= 0) ? (NR'(1) << k) : '0;
        exp_data = '0;
        if (k < 0) begin
            exp_ack = 1'b0; exp_lat = 1; hold = 0;
        end else if (d + 1 <= TO) begin
            exp_ack = 1'b1; exp_lat = d + 1; hold = d + 1;
        end else begin
            exp_ack = 1'b0; exp_lat = TO + 1; hold = TO;
        end
        m_req = 1'b1;
        m_addr = addr;
        @(posedge clk); #1;
        m_req = 1'b0;
        n_total++;
        if (s_sel !== onehot || m_busy !== 1'b1)
            $display("FAIL accept addr=%h: s_sel=%b busy=%b, expected s_sel=%b busy=1", addr, s_sel, m_busy, onehot);
        else n_pass++;
        n_total++;
        if (s_addr !== addr) $display("FAIL s_addr_latch: got %h expected %h", s_addr, addr);
        else n_pass++;
        lat = 0;
        while (!(m_ack || m_err) && lat < exp_lat + 4) begin
            stray = spur ? (NR'($urandom) & ~onehot) : '0;
            s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (exp_ack && lat + 1 == d + 1) begin
                s_ack = stray | onehot;
                exp_data = s_rdata[k*DW +: DW];
            end else begin
                s_ack = stray;
            end
            if (spur && lat + 1 <= exp_lat && $urandom_range(0, 1) == 1) begin
                m_req = 1'b1;
                m_addr = rand_addr();
            end
            @(posedge clk); #1;
            lat++;
            s_ack = '0;
            m_req = 1'b0;
            if (!(m_ack || m_err)) begin
                n_total++;
                if (s_sel !== ((lat < hold) ? onehot : '0) || m_busy !== 1'b1)
                    $display("FAIL in_flight addr=%h cyc=%0d: s_sel=%b busy=%b, expected s_sel=%b busy=1",
                             addr, lat, s_sel, m_busy, (lat < hold) ? onehot : '0);
                else n_pass++;
            end
        end
        if (exp_ack) exp_rdata = exp_data;
        else begin
            exp_err_addr = addr;
            if (exp_err_count < 255) exp_err_count++;
        end
        n_total++;
        if (lat !== exp_lat) $display("FAIL latency addr=%h: got %0d expected %0d", addr, lat, exp_lat);
        else n_pass++;
        n_total++;
        if (m_ack !== exp_ack || m_err !== !exp_ack)
            $display("FAIL outcome addr=%h: ack=%b err=%b, expected ack=%b err=%b", addr, m_ack, m_err, exp_ack, !exp_ack);
        else n_pass++;
        n_total++;
        if (m_busy !== 1'b0 || s_sel !== '0)
            $display("FAIL idle_after addr=%h: busy=%b s_sel=%b, expected 0", addr, m_busy, s_sel);
        else n_pass++;
        n_total++;
        if (m_rdata !== exp_rdata) $display("FAIL m_rdata addr=%h: got %h expected %h", addr, m_rdata, exp_rdata);
        else n_pass++;
        n_total++;
        if (err_addr !== exp_err_addr || err_count !== EW'(exp_err_count))
            $display("FAIL err_log addr=%h: err_addr=%h count=%0d, expected %h %0d",
                     addr, err_addr, err_count, exp_err_addr, exp_err_count);
        else n_pass++;
        n_total++;
        if (s_addr !== addr) $display("FAIL s_addr_hold: got %h expected %h", s_addr, addr);
        else n_pass++;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        n_total++;
        if (m_ack !== 1'b0 || m_err !== 1'b0 || m_busy !== 1'b0 || m_rdata !== exp_rdata)
            $display("FAIL idle_pulse: ack=%b err=%b busy=%b rdata=%h, expected 0 0 0 %h",
                     m_ack, m_err, m_busy, m_rdata, exp_rdata);
        else n_pass++;
    endtask

    task automatic check_all_zero(input string tag);
        n_total++;
        if (m_busy !== 0 || m_ack !== 0 || m_err !== 0 || m_rdata !== 0 || s_sel !== 0 ||
            s_addr !== 0 || err_addr !== 0 || err_count !== 0)
            $display("FAIL %s: busy=%b ack=%b err=%b rdata=%h sel=%b saddr=%h eaddr=%h ecnt=%0d, expected all 0",
                     tag, m_busy, m_ack, m_err, m_rdata, s_sel, s_addr, err_addr, err_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        model_reset();
        idle_cycle();
    endtask

    task automatic test_directed();
        run_txn(32'h0500_001F, 0, 0);
        idle_cycle();
        run_txn(32'h0000_7FFF, 1, 0);
        run_txn(32'h0000_8000, 0, 0);
        n_total++;
        if (err_count !== 8'd1) $display("FAIL first_err_count: got %0d expected 1", err_count);
        else n_pass++;
        run_txn(32'h0BFF_FFFF, 2, 0);
        run_txn(32'h0800_0000, 10, 0);
        run_txn(32'h0800_0000, TO - 1, 0);
        idle_cycle();
    endtask

    task automatic test_ignored_during_access();
        run_txn(32'h0040_0000, 2, 1);
        run_txn(32'h0401_0004, 1, 0);
        idle_cycle();
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 260; i++) run_txn(32'h0200_0000 + i, 0, 0);
        n_total++;
        if (err_count !== 8'd255) $display("FAIL err_saturation: got %0d expected 255", err_count);
        else n_pass++;
        idle_cycle();
    endtask

    task automatic test_reset_mid_access();
        m_req = 1'b1;
        m_addr = 32'h0040_0100;
        @(posedge clk); #1;
        m_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("reset_mid_access");
        model_reset();
        s_ack = '1;
        for (int i = 0; i < 6; i++) idle_cycle();
        s_ack = '0;
        run_txn(32'h0040_0100, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            run_txn(rand_addr(), $urandom_range(0, TO + 1), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

    initial begin
        base_t  = '{32'h0000_0000, 32'h0040_0000, 32'h0401_0000, 32'h0800_0000, 32'h0500_0000, 32'h0500_0010};
        limit_t = '{32'h0000_7FFF, 32'h0040_FFFF, 32'h0401_000F, 32'h0BFF_FFFF, 32'h0500_000F, 32'h0500_001F};
        reset = 1'b1;
        m_req = 1'b0;
        m_addr = '0;
        s_ack = '0;
        s_rdata = '0;
        model_reset();
        test_reset();
        test_directed();
        test_ignored_during_access();
        test_err_saturation();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
